// File: rtl/ci_opcode_packer.sv
// ci_opcode_packer
// Packs a stream of decoded conditional-increment operations into consecutive
// 38-bit opcode slots of an execution EV and emits the assembled EV.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   ev_in / ev_in_valid /     EV to be programmed (valid/ready handshake)
//     ev_in_ready
//   op_valid / op_ready       op handshake; op_* fields describe one operation
//   op_target, op_cmp, op_a,  slot fields, copied verbatim into the slot
//     op_b, op_flag, op_fcond
//   op_last                   final op of the current EV
//   ev_out / ev_out_valid /   assembled EV (valid/ready handshake)
//     ev_out_ready
//   slot_count                slots filled in the current EV
//   overflow_err              sticky: an op was dropped because slots were full
module ci_opcode_packer #(
  parameter int         EV_W    = 1024,
  parameter int         OPC_LSB = 512,
  parameter int         OPC_W   = 256,
  parameter logic [7:0] CI_OPID = 8'h2C,
  parameter int         SLOT_W  = 38
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [EV_W-1:0] ev_in,
  input  logic            ev_in_valid,
  output logic            ev_in_ready,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [3:0]      op_target,
  input  logic [2:0]      op_cmp,
  input  logic [8:0]      op_a,
  input  logic [8:0]      op_b,
  input  logic [2:0]      op_flag,
  input  logic [1:0]      op_fcond,
  input  logic            op_last,
  output logic [EV_W-1:0] ev_out,
  output logic            ev_out_valid,
  input  logic            ev_out_ready,
  output logic [2:0]      slot_count,
  output logic            overflow_err
);

  localparam int         MAX_SLOTS   = OPC_W / SLOT_W;
  localparam logic [2:0] MAX_SLOTS_C = 3'(MAX_SLOTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [EV_W-1:0]   ev_q, ev_d;
  logic [2:0]        slot_count_q, slot_count_d;
  logic              overflow_q, overflow_d;
  logic              ev_out_valid_q, ev_out_valid_d;
  logic [SLOT_W-1:0] slot_s;

  // A freshly captured EV has its whole opcode field cleared, so every unused
  // slot reads as OPID 0 (end-of-program) for the executor.
  function automatic logic [EV_W-1:0] strip_opcode(input logic [EV_W-1:0] ev);
    logic [EV_W-1:0] r;
    r = ev;
    r[OPC_LSB +: OPC_W] = '0;
    return r;
  endfunction

  // Slot image of the offered op, LSB first: id, target, cmp, opA, opB, flag, fcond.
  assign slot_s = {op_fcond, op_flag, op_b, op_a, op_cmp, op_target, CI_OPID};

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d        = state_q;
    ev_d           = ev_q;
    slot_count_d   = slot_count_q;
    overflow_d     = overflow_q;
    ev_in_ready    = 1'b0;
    op_ready       = 1'b0;
    case (state_q)
      IDLE: begin
        ev_in_ready = 1'b1;
        if (ev_in_valid) begin
          ev_d         = strip_opcode(ev_in);
          slot_count_d = 3'd0;
          overflow_d   = 1'b0;
          state_d      = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (slot_count_q < MAX_SLOTS_C) begin
            for (int k = 0; k < MAX_SLOTS; k++) begin
              ev_d[OPC_LSB + k*SLOT_W +: SLOT_W] = (slot_count_q == 3'(k)) ?
                  slot_s : ev_q[OPC_LSB + k*SLOT_W +: SLOT_W];
            end
            slot_count_d = slot_count_q + 3'd1;
          end else begin
            overflow_d = 1'b1;
          end
          if (op_last) begin
            state_d = EMIT;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      EMIT: begin
        // Accepting the next EV in the same cycle as the output handshake
        // keeps back-to-back programs free of an idle bubble.
        ev_in_ready = ev_out_ready;
        if (ev_out_ready) begin
          if (ev_in_valid) begin
            ev_d         = strip_opcode(ev_in);
            slot_count_d = 3'd0;
            overflow_d   = 1'b0;
            state_d      = FILL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ev_out_valid_d = (state_d == EMIT);
  end

  // State and datapath registers; reset discards any EV in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ev_q           <= '0;
      slot_count_q   <= 3'd0;
      overflow_q     <= 1'b0;
      ev_out_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ev_q           <= ev_d;
      slot_count_q   <= slot_count_d;
      overflow_q     <= overflow_d;
      ev_out_valid_q <= ev_out_valid_d;
    end
  end

  assign ev_out       = ev_q;
  assign ev_out_valid = ev_out_valid_q;
  assign slot_count   = slot_count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_ci_opcode_packer.sv
// Directed, table-driven bench for ci_opcode_packer.
module tb_ci_opcode_packer;

  localparam int EV_W = 1024;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [EV_W-1:0] ev_in;
  logic            ev_in_valid;
  logic            ev_in_ready;
  logic            op_valid;
  logic            op_ready;
  logic [3:0]      op_target;
  logic [2:0]      op_cmp;
  logic [8:0]      op_a;
  logic [8:0]      op_b;
  logic [2:0]      op_flag;
  logic [1:0]      op_fcond;
  logic            op_last;
  logic [EV_W-1:0] ev_out;
  logic            ev_out_valid;
  logic            ev_out_ready;
  logic [2:0]      slot_count;
  logic            overflow_err;

  int checks = 0;
  int errors = 0;

  ci_opcode_packer dut (
    .clk(clk), .reset_n(reset_n),
    .ev_in(ev_in), .ev_in_valid(ev_in_valid), .ev_in_ready(ev_in_ready),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_target(op_target), .op_cmp(op_cmp), .op_a(op_a), .op_b(op_b),
    .op_flag(op_flag), .op_fcond(op_fcond), .op_last(op_last),
    .ev_out(ev_out), .ev_out_valid(ev_out_valid), .ev_out_ready(ev_out_ready),
    .slot_count(slot_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  target;
    logic [2:0]  cmp;
    logic [8:0]  a;
    logic [8:0]  b;
    logic [2:0]  flag;
    logic [1:0]  fcond;
    logic        last;
    logic [37:0] exp;
  } vec_t;

  localparam logic [2:0] ALTB = 3'd0;
  localparam logic [2:0] AGTB = 3'd1;

  vec_t            tbl [4];
  logic [EV_W-1:0] opc_mask;
  logic [EV_W-1:0] ev_a, ev_b, ev_c, ev_d;
  logic [EV_W-1:0] cur_ev;
  logic [37:0]     ovf_exp [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] slot_of(input logic [EV_W-1:0] ev, input int k);
    return ev[512 + k*38 +: 38];
  endfunction

  function automatic logic [EV_W-1:0] make_ev(input logic [63:0] seed);
    logic [EV_W-1:0] r;
    for (int w = 0; w < 16; w++) r[w*64 +: 64] = seed ^ (64'(w) * 64'h0101_0101_0101_0101);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ev(input logic [EV_W-1:0] ev);
    ev_in       = ev;
    ev_in_valid = 1'b1;
    #1;
    chk("ev_in_ready_idle", 64'(ev_in_ready), 64'd1);
    tick();
    ev_in_valid = 1'b0;
    chk("op_ready_fill", 64'(op_ready), 64'd1);
    chk("slot_count_start", 64'(slot_count), 64'd0);
  endtask

  task automatic send_op(input logic [3:0] t, input logic [2:0] c, input logic [8:0] a,
                         input logic [8:0] b, input logic [2:0] f, input logic [1:0] fc,
                         input logic l);
    op_target = t; op_cmp = c; op_a = a; op_b = b; op_flag = f; op_fcond = fc;
    op_last = l; op_valid = 1'b1;
    #1;
    chk("op_ready", 64'(op_ready), 64'd1);
    tick();
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  task automatic chk_passthru(input logic [EV_W-1:0] ev);
    chk("passthru", 64'((ev_out & ~opc_mask) == (ev & ~opc_mask)), 64'd1);
    chk("opc_tail_zero", 64'(ev_out[767:740]), 64'd0);
  endtask

  task automatic accept_out();
    ev_out_ready = 1'b1;
    tick();
    ev_out_ready = 1'b0;
    chk("valid_drop", 64'(ev_out_valid), 64'd0);
    chk("ev_in_ready_back_idle", 64'(ev_in_ready), 64'd1);
  endtask

  initial begin
    int n;
    int first;

    reset_n = 1'b0; ev_in = '0; ev_in_valid = 1'b0; op_valid = 1'b0;
    op_target = 4'd0; op_cmp = 3'd0; op_a = 9'd0; op_b = 9'd0; op_flag = 3'd0;
    op_fcond = 2'd0; op_last = 1'b0; ev_out_ready = 1'b0;

    opc_mask = '0;
    opc_mask[767:512] = '1;

    ev_a = make_ev(64'hA5A5_0000_1234_5678);
    ev_a[1*64 +: 64] = 64'd35;
    ev_a[2*64 +: 64] = 64'd67;
    ev_a[3*64 +: 64] = 64'd10;
    ev_a[4*64 +: 64] = 64'd94;
    ev_a[5*64 +: 64] = 64'd154;
    ev_b = make_ev(64'h0F0F_F0F0_DEAD_BEEF);
    ev_c = make_ev(64'h1357_9BDF_2468_ACE0);
    ev_d = make_ev(64'hFFFF_0000_FFFF_0000);

    tbl[0] = '{4'd1, ALTB, 9'h002, 9'h101, 3'd0, 2'b00, 1'b1,
               {2'b00, 3'd0, 9'h101, 9'h002, ALTB, 4'd1, 8'h2C}};
    tbl[1] = '{4'd2, ALTB, 9'h005, 9'h10F, 3'd2, 2'b00, 1'b0,
               {2'b00, 3'd2, 9'h10F, 9'h005, ALTB, 4'd2, 8'h2C}};
    tbl[2] = '{4'd2, ALTB, 9'h005, 9'h10F, 3'd1, 2'b10, 1'b0,
               {2'b10, 3'd1, 9'h10F, 9'h005, ALTB, 4'd2, 8'h2C}};
    tbl[3] = '{4'd3, AGTB, 9'h100, 9'h1FE, 3'd1, 2'b00, 1'b1,
               {2'b00, 3'd1, 9'h1FE, 9'h100, AGTB, 4'd3, 8'h2C}};

    #1;
    chk("rst_valid", 64'(ev_out_valid), 64'd0);
    chk("rst_slot_count", 64'(slot_count), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_ev_in_ready", 64'(ev_in_ready), 64'd1);
    chk("rst_ev_out_zero", 64'(ev_out == '0), 64'd1);
    tick();
    reset_n = 1'b1;
    tick();

    // Programs from the table: single op, then three ops.
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (n == 0) begin
        cur_ev = (i == 0) ? ev_a : ev_b;
        send_ev(cur_ev);
      end
      send_op(tbl[i].target, tbl[i].cmp, tbl[i].a, tbl[i].b, tbl[i].flag,
              tbl[i].fcond, tbl[i].last);
      n++;
      if (tbl[i].last) begin
        chk("valid_after_last", 64'(ev_out_valid), 64'd1);
        chk("op_ready_emit", 64'(op_ready), 64'd0);
        chk("slot_count", 64'(slot_count), 64'(n));
        chk("overflow_clear", 64'(overflow_err), 64'd0);
        first = i - n + 1;
        for (int k = 0; k < 6; k++) begin
          if (k < n) chk($sformatf("slot%0d", k), 64'(slot_of(ev_out, k)), 64'(tbl[first + k].exp));
          else       chk($sformatf("slot%0d_zero", k), 64'(slot_of(ev_out, k)), 64'd0);
        end
        chk_passthru(cur_ev);
        accept_out();
        n = 0;
      end
    end

    // Overflow: eight ops, the last two dropped.
    send_ev(ev_c);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] t; logic [2:0] c; logic [8:0] a; logic [8:0] b; logic [2:0] f; logic [1:0] fc;
      t = 4'(i + 5); c = 3'(i); a = 9'(i + 16); b = 9'h100 | 9'(i); f = 3'(i); fc = 2'(i);
      if (i < 6) ovf_exp[i] = {fc, f, b, a, c, t, 8'h2C};
      send_op(t, c, a, b, f, fc, (i == 7));
      if (i == 6) chk("ovf_not_early", 64'(ev_out_valid), 64'd0);
    end
    chk("ovf_valid", 64'(ev_out_valid), 64'd1);
    chk("ovf_flag", 64'(overflow_err), 64'd1);
    chk("ovf_slot_count", 64'(slot_count), 64'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("ovf_slot%0d", k), 64'(slot_of(ev_out, k)), 64'(ovf_exp[k]));
    chk_passthru(ev_c);

    // Backpressure: output held, a pending EV must not be taken.
    ev_in       = ev_d;
    ev_in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_ev_in_ready", 64'(ev_in_ready), 64'd0);
      chk("bp_op_ready", 64'(op_ready), 64'd0);
      chk("bp_valid", 64'(ev_out_valid), 64'd1);
      chk("bp_slot5", 64'(slot_of(ev_out, 5)), 64'(ovf_exp[5]));
      chk("bp_slot0", 64'(slot_of(ev_out, 0)), 64'(ovf_exp[0]));
      chk_passthru(ev_c);
      tick();
    end
    ev_out_ready = 1'b1;
    #1;
    chk("b2b_ev_in_ready", 64'(ev_in_ready), 64'd1);
    tick();
    ev_out_ready = 1'b0;
    ev_in_valid  = 1'b0;
    chk("b2b_valid_drop", 64'(ev_out_valid), 64'd0);
    chk("b2b_op_ready", 64'(op_ready), 64'd1);
    chk("b2b_overflow_clr", 64'(overflow_err), 64'd0);
    chk("b2b_slot_count", 64'(slot_count), 64'd0);
    chk("b2b_captured", 64'((ev_out & ~opc_mask) == (ev_d & ~opc_mask)), 64'd1);
    chk("b2b_opc_zero", 64'(ev_out[767:512] == '0), 64'd1);

    // Reset in the middle of filling.
    send_op(tbl[1].target, tbl[1].cmp, tbl[1].a, tbl[1].b, tbl[1].flag, tbl[1].fcond, 1'b0);
    send_op(tbl[2].target, tbl[2].cmp, tbl[2].a, tbl[2].b, tbl[2].flag, tbl[2].fcond, 1'b0);
    chk("mid_slot_count", 64'(slot_count), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("arst_slot_count", 64'(slot_count), 64'd0);
    chk("arst_op_ready", 64'(op_ready), 64'd0);
    chk("arst_ev_in_ready", 64'(ev_in_ready), 64'd1);
    chk("arst_valid", 64'(ev_out_valid), 64'd0);
    chk("arst_ev_out_zero", 64'(ev_out == '0), 64'd1);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_ev_in_ready", 64'(ev_in_ready), 64'd1);
    chk("post_rst_valid", 64'(ev_out_valid), 64'd0);
    chk("post_rst_op_ready", 64'(op_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
